memory_cycle: RTL
=================

MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL provide parameter MAX_WAIT, default 15: maximum number of WAIT-state cycles before a data-memory access is aborted (range 1..255).
REQ-002 SHALL have one clock and an asynchronous, active-high reset; the clock and reset ports are named clk and rst as elsewhere in the codebase.
REQ-003 SHALL provide the following ports (name, direction, width, meaning):
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous reset, active-high.
- ValidM  in  1  M-stage slot holds a real instruction.
- RegWriteM  in  1  register-file write enable.
- MemWriteM  in  1  store.
- ResultSrcM  in  1  load; result comes from memory.
- RD_M  in  5  destination register.
- PCPlus4M  in  32  PC+4.
- ALU_ResultM  in  32  effective address / ALU result.
- WriteDataM  in  32  store data.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  32  address.
- dmem_wdata  out  32  write data.
- dmem_ready  in  1  memory completes the request this cycle.
- dmem_rdata  in  32  read data, valid when dmem_ready=1.
- StallM  out  1  upstream SHALL hold all M-stage inputs stable.
- ValidW, RegWriteW, ResultSrcW  out  1  registered W-stage controls.
- RD_W  out  5  registered destination register.
- PCPlus4W, ALU_ResultW, ReadDataW  out  32  registered W-stage data.
- MemErrW  out  1  one-cycle pulse marking an aborted access.

Function
REQ-004 SHALL define memop = ValidM & (MemWriteM | ResultSrcM); MemWriteM=1 and ResultSrcM=1 together SHALL be treated as a store.
REQ-005 SHALL implement FSM states IDLE and WAIT, plus an 8-bit wait counter wcnt.
REQ-006 SHALL assert dmem_req=memop combinationally in IDLE and WAIT, with dmem_addr=ALU_ResultM, dmem_wdata=WriteDataM and dmem_we=MemWriteM; when dmem_req=0, dmem_we SHALL be 0.
REQ-007 SHALL handle IDLE as follows:
- memop & dmem_ready: access completes in the same cycle, StallM=0, state stays IDLE (zero-wait).
- memop & ~dmem_ready: StallM=1, next state WAIT, wcnt<=1.
REQ-008 SHALL handle WAIT as follows:
- dmem_ready=1: StallM=0, next state IDLE, wcnt<=0.
- dmem_ready=0 and wcnt<MAX_WAIT: StallM=1, wcnt increments.
- dmem_ready=0 and wcnt==MAX_WAIT (timeout): dmem_req=0 that cycle, StallM=0, next state IDLE.
REQ-009 SHALL pass a non-memop instruction (including ValidM=0) through in one cycle with StallM=0 and no memory request.
REQ-010 SHALL update the W registers on every rising edge:
- StallM=1: insert a bubble (ValidW=0, RegWriteW=0, ResultSrcW=0, MemErrW=0); other W fields are don't-care but SHALL be held.
- Otherwise: ValidW<=ValidM; RegWriteW<=RegWriteM&ValidM; ResultSrcW, RD_W, PCPlus4W and ALU_ResultW take the M values.
- Completed load: ReadDataW<=dmem_rdata; all other cases: ReadDataW<=0.
- Timeout: RegWriteW<=0, ReadDataW<=0, MemErrW<=1, ValidW<=1.
REQ-011 SHALL give a total latency of 1 cycle for a zero-wait access, N+1 cycles for an access with N wait cycles, and MAX_WAIT+1 cycles for a timed-out access.
REQ-012 SHALL ignore dmem_ready while dmem_req=0.
REQ-013 SHALL keep MemErrW high for exactly one cycle per timeout.

Reset
REQ-014 SHALL, while rst=1 (asynchronously), force state=IDLE, wcnt=0, and all W outputs and MemErrW to 0.
REQ-015 SHALL hold dmem_req and StallM at 0 while rst=1; a reset during WAIT SHALL abandon the access with no W update and no MemErrW.

Verification
REQ-016 Zero-wait load: ValidM=1, ResultSrcM=1, ALU_ResultM=0x100, RD_M=5, dmem_ready=1, dmem_rdata=0xDEADBEEF -> next cycle ValidW=1, RegWriteW=1, RD_W=5, ReadDataW=0xDEADBEEF, and StallM never asserts.
REQ-017 3-wait store: MemWriteM=1, WriteDataM=0x12345678, ALU_ResultM=0x40, dmem_ready low for 3 cycles -> StallM=1 for 3 cycles; dmem_req, dmem_we and dmem_addr=0x40 stay stable; W shows 3 bubbles then ValidW=1, RegWriteW=0.
REQ-018 Timeout with MAX_WAIT=4 and dmem_ready held 0 -> StallM=1 for 4 cycles, then dmem_req=0 and StallM=0; the next edge gives MemErrW=1 for one cycle, ValidW=1, RegWriteW=0.
REQ-019 Non-memop ALU op: ALU_ResultM=0x7, RegWriteM=1 -> ALU_ResultW=0x7, ReadDataW=0 one cycle later; dmem_req stays 0.
REQ-020 Reset mid-WAIT: assert rst after 2 wait cycles -> W outputs, StallM and dmem_req are 0 immediately; after release, state is IDLE and MemErrW is never pulsed.
REQ-021 Back-to-back: a zero-wait load followed by a zero-wait store on consecutive cycles -> two consecutive ValidW=1 cycles with no bubble.

Source files
------------

// File: rtl/memory_cycle.sv
// memory_cycle: M-stage data-memory access with wait states, timeout abort and W-stage register
module memory_cycle #(
   parameter int MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ValidM,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic        ResultSrcM,
   input  logic [4:0]  RD_M,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] ALU_ResultM,
   input  logic [31:0] WriteDataM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        StallM,
   output logic        ValidW,
   output logic        RegWriteW,
   output logic        ResultSrcW,
   output logic [4:0]  RD_W,
   output logic [31:0] PCPlus4W,
   output logic [31:0] ALU_ResultW,
   output logic [31:0] ReadDataW,
   output logic        MemErrW
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t     state;
   logic [7:0] wcnt;
   logic       memop, is_load, timeout;
   // decode the access; a timed-out access drops its request in the final cycle
   always_comb begin
      memop    = ValidM & (MemWriteM | ResultSrcM);
      is_load  = ResultSrcM & ~MemWriteM;
      timeout  = (state == WAIT) & ~dmem_ready & (wcnt == 8'(MAX_WAIT));
      dmem_req = ~rst & memop & ~timeout;
      dmem_we  = dmem_req & MemWriteM;
      StallM   = dmem_req & ~dmem_ready;
   end
   assign dmem_addr  = ALU_ResultM;
   assign dmem_wdata = WriteDataM;
   // wait-state tracking and W-stage register: bubbles while stalled, error slot on timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wcnt        <= '0;
         ValidW      <= 1'b0;
         RegWriteW   <= 1'b0;
         ResultSrcW  <= 1'b0;
         RD_W        <= '0;
         PCPlus4W    <= '0;
         ALU_ResultW <= '0;
         ReadDataW   <= '0;
         MemErrW     <= 1'b0;
      end else begin
         state   <= StallM ? WAIT : IDLE;
         wcnt    <= StallM ? wcnt + 8'd1 : 8'd0;
         MemErrW <= timeout;
         if (StallM) begin
            ValidW     <= 1'b0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
         end else begin
            ValidW      <= ValidM | timeout;
            RegWriteW   <= RegWriteM & ValidM & ~timeout;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= (memop & is_load & dmem_ready) ? dmem_rdata : '0;
         end
      end
   end
endmodule
